// File: rtl/pc_unit_v2_if.sv
// Decode/fetch-side bundle of the PC unit: redirect controls, ALU flags and the PC/RAS views.
interface pc_unit_v2_if;
    logic        Stall;
    logic        Jump;
    logic        JumpReg;
    logic        Branch;
    logic [2:0]  BrCond;
    logic        ALUZero;
    logic        ALUNeg;
    logic        Link;
    logic        Return;
    logic        Exception;
    logic        ERet;
    logic [25:0] JumpTarget;
    logic [15:0] BranchOffset;
    logic [31:0] RegTarget;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [31:0] EPC;
    logic [31:0] RASTop;
    logic        RASEmpty;
    logic        Misaligned;

    modport master (
        output Stall, Jump, JumpReg, Branch, BrCond, ALUZero, ALUNeg, Link, Return,
               Exception, ERet, JumpTarget, BranchOffset, RegTarget,
        input  PC, PCPlus4, EPC, RASTop, RASEmpty, Misaligned
    );

    modport slave (
        input  Stall, Jump, JumpReg, Branch, BrCond, ALUZero, ALUNeg, Link, Return,
               Exception, ERet, JumpTarget, BranchOffset, RegTarget,
        output PC, PCPlus4, EPC, RASTop, RASEmpty, Misaligned
    );
endinterface

// File: rtl/pc_unit_v2.sv
// Program-counter unit: branches, jumps, exception/ERET with EPC and a circular return-address stack.
// Optional branch-delay-slot behaviour is enabled by defining PCU_DELAY_SLOT_EN.
module pc_unit_v2 #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_4180,
    parameter int          RAS_DEPTH    = 4
) (
    input logic         CLK,
    input logic         RST,
    pc_unit_v2_if.slave bus
);
    localparam int            PW       = $clog2(RAS_DEPTH);
    localparam int            CW       = $clog2(RAS_DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   epc_q, epc_d;
    logic [31:0]   ras_q [RAS_DEPTH];
    logic [31:0]   ras_d [RAS_DEPTH];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   ras_top_q, ras_top_d;
    logic          ras_empty_q, ras_empty_d;
    logic          misaligned_q, misaligned_d;

    logic [31:0] pc_plus4_s, jump_tgt_s, br_tgt_s, redir_tgt_s, push_val_s;
    logic        br_taken_s, redirect_s, mis_s, exc_s, ras_en_s, push_s, pop_s, idle_s;

`ifdef PCU_DELAY_SLOT_EN
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PENDING = 1'b1} state_e;
    state_e      state_q, state_d;
    logic [31:0] pend_q, pend_d;
    assign idle_s = (state_q == ST_IDLE);
`else
    assign idle_s = 1'b1;
`endif

    // Decode redirect source, branch condition, misalignment and RAS push/pop requests.
    always_comb begin
        pc_plus4_s = pc_q + 32'd4;
        jump_tgt_s = {pc_plus4_s[31:28], bus.JumpTarget, 2'b00};
        br_tgt_s   = pc_plus4_s + {{14{bus.BranchOffset[15]}}, bus.BranchOffset, 2'b00};
        case (bus.BrCond)
            3'b000:  br_taken_s = bus.ALUZero;
            3'b001:  br_taken_s = ~bus.ALUZero;
            3'b010:  br_taken_s = bus.ALUZero | bus.ALUNeg;
            3'b011:  br_taken_s = ~bus.ALUZero & ~bus.ALUNeg;
            3'b100:  br_taken_s = bus.ALUNeg;
            3'b101:  br_taken_s = ~bus.ALUNeg;
            default: br_taken_s = 1'b0;
        endcase
        if (bus.JumpReg) begin
            redir_tgt_s = bus.RegTarget;
        end else if (bus.Jump) begin
            redir_tgt_s = jump_tgt_s;
        end else begin
            redir_tgt_s = br_tgt_s;
        end
        redirect_s = bus.JumpReg | bus.Jump | (bus.Branch & br_taken_s);
        // A stalled or delay-slot-resolving JumpReg is not a live transfer, so it cannot fault.
        mis_s    = idle_s & ~bus.Stall & bus.JumpReg & (bus.RegTarget[1:0] != 2'b00);
        exc_s    = bus.Exception | mis_s;
        ras_en_s = idle_s & ~exc_s & ~bus.ERet & ~bus.Stall & (bus.Jump | bus.JumpReg);
        push_s   = ras_en_s & bus.Link;
        pop_s    = ras_en_s & bus.JumpReg & bus.Return;
`ifdef PCU_DELAY_SLOT_EN
        push_val_s = pc_q + 32'd8;
`else
        push_val_s = pc_plus4_s;
`endif
    end

    // Next PC / EPC selection in priority order.
    always_comb begin
        epc_d        = epc_q;
        misaligned_d = mis_s;
`ifdef PCU_DELAY_SLOT_EN
        state_d = state_q;
        pend_d  = pend_q;
        if (exc_s) begin
            pc_d    = EXC_VECTOR;
            epc_d   = pc_q;
            state_d = ST_IDLE;
            pend_d  = 32'h0000_0000;
        end else if (bus.ERet) begin
            pc_d    = epc_q;
            state_d = ST_IDLE;
            pend_d  = 32'h0000_0000;
        end else if (bus.Stall) begin
            pc_d = pc_q;
        end else if (state_q == ST_PENDING) begin
            pc_d    = pend_q;
            state_d = ST_IDLE;
        end else if (redirect_s) begin
            pc_d    = pc_plus4_s;
            pend_d  = redir_tgt_s;
            state_d = ST_PENDING;
        end else begin
            pc_d = pc_plus4_s;
        end
`else
        if (exc_s) begin
            pc_d  = EXC_VECTOR;
            epc_d = pc_q;
        end else if (bus.ERet) begin
            pc_d = epc_q;
        end else if (bus.Stall) begin
            pc_d = pc_q;
        end else if (redirect_s) begin
            pc_d = redir_tgt_s;
        end else begin
            pc_d = pc_plus4_s;
        end
`endif
    end

    // Return-address stack: circular buffer, push-when-full overwrites the oldest entry.
    always_comb begin
        ras_d = ras_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push_s && pop_s && (cnt_q != {CW{1'b0}})) begin
            ras_d[ptr_q] = push_val_s;
        end else if (push_s) begin
            ptr_d        = ptr_q + PTR_ONE;
            ras_d[ptr_d] = push_val_s;
            if (cnt_q != CNT_FULL) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end else if (pop_s && (cnt_q != {CW{1'b0}})) begin
            ptr_d = ptr_q - PTR_ONE;
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
        ras_empty_d = (cnt_d == {CW{1'b0}});
        if (ras_empty_d) begin
            ras_top_d = 32'h0000_0000;
        end else begin
            ras_top_d = ras_d[ptr_d];
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pc_q         <= RESET_VECTOR;
            epc_q        <= 32'h0000_0000;
            ptr_q        <= {PW{1'b0}};
            cnt_q        <= {CW{1'b0}};
            ras_top_q    <= 32'h0000_0000;
            ras_empty_q  <= 1'b1;
            misaligned_q <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= 32'h0000_0000;
            end
`ifdef PCU_DELAY_SLOT_EN
            state_q <= ST_IDLE;
            pend_q  <= 32'h0000_0000;
`endif
        end else begin
            pc_q         <= pc_d;
            epc_q        <= epc_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            ras_top_q    <= ras_top_d;
            ras_empty_q  <= ras_empty_d;
            misaligned_q <= misaligned_d;
            ras_q        <= ras_d;
`ifdef PCU_DELAY_SLOT_EN
            state_q <= state_d;
            pend_q  <= pend_d;
`endif
        end
    end

    assign bus.PC         = pc_q;
    assign bus.PCPlus4    = pc_plus4_s;
    assign bus.EPC        = epc_q;
    assign bus.RASTop     = ras_top_q;
    assign bus.RASEmpty   = ras_empty_q;
    assign bus.Misaligned = misaligned_q;
endmodule

// File: tb/tb_pc_unit_v2.sv
// Self-checking bench for pc_unit_v2: directed plan steps plus random traffic against a queue-based model.
module tb_pc_unit_v2;
    localparam int DEPTH = 4;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    pc_unit_v2_if bus ();
    pc_unit_v2 dut (.CLK(CLK), .RST(RST), .bus(bus));

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] m_pc, m_epc;
    logic        m_mis;
    logic [31:0] m_ras[$];
    logic [31:0] pv [5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.Stall = 1'b0; bus.Jump = 1'b0; bus.JumpReg = 1'b0; bus.Branch = 1'b0;
        bus.BrCond = 3'b000; bus.ALUZero = 1'b0; bus.ALUNeg = 1'b0; bus.Link = 1'b0;
        bus.Return = 1'b0; bus.Exception = 1'b0; bus.ERet = 1'b0;
        bus.JumpTarget = 26'h0; bus.BranchOffset = 16'h0; bus.RegTarget = 32'h0;
    endtask

    task automatic model_reset();
        m_pc = 32'h0000_3000; m_epc = 32'h0; m_mis = 1'b0; m_ras.delete();
    endtask

    // Next state from the architectural rules applied to the driven inputs.
    task automatic model_update();
        logic [31:0] p4, nxt;
        logic        mis, taken;
        p4  = m_pc + 32'd4;
        mis = bus.JumpReg && (bus.RegTarget[1:0] != 2'b00) && !bus.Stall;
        case (bus.BrCond)
            3'd0: taken = bus.ALUZero;
            3'd1: taken = !bus.ALUZero;
            3'd2: taken = bus.ALUZero || bus.ALUNeg;
            3'd3: taken = !bus.ALUZero && !bus.ALUNeg;
            3'd4: taken = bus.ALUNeg;
            3'd5: taken = !bus.ALUNeg;
            default: taken = 1'b0;
        endcase
        nxt = p4;
        if (bus.Exception || mis) begin
            m_epc = m_pc;
            nxt   = 32'h0000_4180;
        end else if (bus.ERet) begin
            nxt = m_epc;
        end else if (bus.Stall) begin
            nxt = m_pc;
        end else begin
            if (bus.JumpReg) nxt = bus.RegTarget;
            else if (bus.Jump) nxt = (p4 & 32'hF000_0000) | (32'(bus.JumpTarget) * 32'd4);
            else if (bus.Branch && taken) nxt = p4 + 32'($signed(bus.BranchOffset)) * 32'd4;
            if (bus.Jump || bus.JumpReg) begin
                if (bus.JumpReg && bus.Return && m_ras.size() > 0) void'(m_ras.pop_back());
                if (bus.Link) begin
                    m_ras.push_back(p4);
                    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                end
            end
        end
        m_pc  = nxt;
        m_mis = mis;
    endtask

    task automatic check_all();
        logic [31:0] top;
        top = (m_ras.size() == 0) ? 32'h0 : m_ras[m_ras.size() - 1];
        chk("PC", bus.PC, m_pc);
        chk("PCPlus4", bus.PCPlus4, m_pc + 32'd4);
        chk("EPC", bus.EPC, m_epc);
        chk("RASTop", bus.RASTop, top);
        chk("RASEmpty", {31'b0, bus.RASEmpty}, {31'b0, m_ras.size() == 0});
        chk("Misaligned", {31'b0, bus.Misaligned}, {31'b0, m_mis});
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic step();
        model_update();
        tick();
        check_all();
    endtask

    initial begin
        idle();
        RST = 1'b0;
        model_reset();
        #12;
        check_all();
        RST = 1'b1;
`ifndef PCU_DELAY_SLOT_EN
        repeat (3) step();
        chk("idle_pc", bus.PC, 32'h0000_300C);
        step();
        bus.Branch = 1'b1; bus.BrCond = 3'b001; bus.ALUZero = 1'b0; bus.BranchOffset = 16'hFFFC;
        step();
        chk("bne_taken", bus.PC, 32'h0000_3004);
        idle();
        repeat (3) step();
        bus.Branch = 1'b1; bus.BrCond = 3'b001; bus.ALUZero = 1'b1; bus.BranchOffset = 16'hFFFC;
        step();
        chk("bne_not_taken", bus.PC, 32'h0000_3014);

        idle(); bus.JumpReg = 1'b1; bus.RegTarget = 32'h0000_3000;
        step();
        idle(); bus.Jump = 1'b1; bus.Link = 1'b1; bus.JumpTarget = 26'h000_1000;
        step();
        chk("jal_pc", bus.PC, 32'h0000_4000);
        chk("jal_rastop", bus.RASTop, 32'h0000_3004);
        idle(); bus.JumpReg = 1'b1; bus.Return = 1'b1; bus.RegTarget = 32'h0000_3004;
        step();
        chk("jr_ret_pc", bus.PC, 32'h0000_3004);
        chk("jr_ret_empty", {31'b0, bus.RASEmpty}, 32'd1);

        for (int i = 0; i < 5; i++) begin
            idle(); bus.Jump = 1'b1; bus.Link = 1'b1;
            bus.JumpTarget = 26'h000_0C00 + 26'(i * 8);
            pv[i] = m_pc + 32'd4;
            step();
        end
        chk("ras_full_top", bus.RASTop, pv[4]);
        for (int i = 0; i < 5; i++) begin
            idle(); bus.JumpReg = 1'b1; bus.Return = 1'b1; bus.RegTarget = 32'h0000_3000;
            step();
            chk("ras_pop_top", bus.RASTop, (i < 3) ? pv[3 - i] : 32'h0);
        end
        chk("ras_pop_empty", {31'b0, bus.RASEmpty}, 32'd1);

        idle(); bus.JumpReg = 1'b1; bus.RegTarget = 32'h0000_3020;
        step();
        bus.RegTarget = 32'h0000_3002;
        step();
        chk("mis_pc", bus.PC, 32'h0000_4180);
        chk("mis_epc", bus.EPC, 32'h0000_3020);
        chk("mis_flag", {31'b0, bus.Misaligned}, 32'd1);
        idle(); bus.ERet = 1'b1;
        step();
        chk("eret_pc", bus.PC, 32'h0000_3020);
        chk("mis_clear", {31'b0, bus.Misaligned}, 32'd0);

        idle(); bus.Stall = 1'b1; bus.JumpReg = 1'b1; bus.RegTarget = 32'h0000_0001;
        step();
        chk("stall_mis_ignored", bus.PC, 32'h0000_3020);
        idle(); bus.Stall = 1'b1; bus.Exception = 1'b1; bus.ERet = 1'b1;
        step();
        chk("exc_over_eret", bus.PC, 32'h0000_4180);
        idle(); bus.ERet = 1'b1;
        step();
        idle(); bus.Branch = 1'b1; bus.BrCond = 3'b110; bus.ALUZero = 1'b1; bus.BranchOffset = 16'h0040;
        step();
        chk("brcond_110", bus.PC, 32'h0000_3024);
        idle(); bus.JumpReg = 1'b1; bus.RegTarget = 32'hFFFF_FFFC;
        step();
        idle();
        step();
        chk("pc_wrap", bus.PC, 32'h0000_0000);

        for (int n = 0; n < 400; n++) begin
            idle();
            bus.Stall        = ($urandom_range(7) == 0);
            bus.Exception    = ($urandom_range(31) == 0);
            bus.ERet         = ($urandom_range(31) == 0);
            bus.Jump         = ($urandom_range(5) == 0);
            bus.JumpReg      = ($urandom_range(5) == 0);
            bus.Branch       = ($urandom_range(3) == 0);
            bus.BrCond       = 3'($urandom_range(7));
            bus.ALUZero      = 1'($urandom_range(1));
            bus.ALUNeg       = 1'($urandom_range(1));
            bus.Link         = 1'($urandom_range(1));
            bus.Return       = 1'($urandom_range(1));
            bus.JumpTarget   = 26'($urandom);
            bus.BranchOffset = 16'($urandom);
            bus.RegTarget    = {$urandom_range(32'h3FFF_FFFF) , 2'b00} |
                               (($urandom_range(7) == 0) ? 32'(2'($urandom_range(3))) : 32'h0);
            step();
        end

        idle(); bus.Jump = 1'b1; bus.Link = 1'b1; bus.JumpTarget = 26'h000_0123;
        step();
        idle();
        #3;
        RST = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge CLK);
        RST = 1'b1;
        repeat (4) step();
`else
        bus.Jump = 1'b1; bus.Link = 1'b1; bus.JumpTarget = 26'h000_0C40;
        tick();
        chk("ds_slot_pc", bus.PC, 32'h0000_3004);
        chk("ds_link", bus.RASTop, 32'h0000_3008);
        idle(); bus.Stall = 1'b1;
        tick();
        chk("ds_stall1", bus.PC, 32'h0000_3004);
        tick();
        chk("ds_stall2", bus.PC, 32'h0000_3004);
        idle(); bus.Jump = 1'b1; bus.JumpTarget = 26'h000_0000;
        tick();
        chk("ds_target", bus.PC, 32'h0000_3100);
        idle();
        tick();
        chk("ds_after", bus.PC, 32'h0000_3104);
        bus.Branch = 1'b1; bus.BrCond = 3'b000; bus.ALUZero = 1'b1; bus.BranchOffset = 16'h0010;
        tick();
        chk("ds_br_slot", bus.PC, 32'h0000_3108);
        idle(); bus.Exception = 1'b1;
        tick();
        chk("ds_exc_pc", bus.PC, 32'h0000_4180);
        chk("ds_exc_epc", bus.EPC, 32'h0000_3108);
        idle();
        tick();
        chk("ds_exc_cleared", bus.PC, 32'h0000_4184);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_unit_v2.md
Name: pc_unit_v2

Overview:
- Parametrised program-counter unit for the MIPS core; next generation of the single-width, fixed-vector PC unit.
- Adds stall, six branch conditions, register-indirect jumps, an exception/ERET path with an internal EPC, and a small return-address stack (RAS) whose top is exported for fetch prediction.
- Sits between the fetch stage and instruction memory; control inputs come from decode and ALU flags.

Parameters:
- RESET_VECTOR, 32'h0000_3000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_4180, PC value loaded on an exception.
- RAS_DEPTH, 4, number of RAS entries; power of two, 2..16.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; asynchronous, active-low.
- Stall  in  1  hold PC and RAS.
- Jump  in  1  J/JAL-type transfer.
- JumpReg  in  1  JR/JALR-type transfer.
- Branch  in  1  conditional branch.
- BrCond  in  3  branch condition select.
- ALUZero  in  1  ALU result is zero.
- ALUNeg  in  1  ALU result is negative.
- Link  in  1  push the return address on a taken Jump or JumpReg.
- Return  in  1  pop the RAS on a taken JumpReg.
- Exception  in  1  take an exception.
- ERet  in  1  return from exception.
- JumpTarget  in  26  instr_index field.
- BranchOffset  in  16  signed word offset.
- RegTarget  in  32  rs value for JumpReg.
- PC  out  32  current PC (register).
- PCPlus4  out  32  PC+4 (combinational).
- EPC  out  32  saved exception PC.
- RASTop  out  32  top RAS entry; 0 when empty.
- RASEmpty  out  1  RAS holds no entries.
- Misaligned  out  1  one-cycle pulse after a misaligned JumpReg.

Behaviour:
- Reset (RST=0, asynchronous): PC=RESET_VECTOR, EPC=0, RAS count=0, all RAS entries=0, Misaligned=0.
- Next-PC priority, highest first:
  1. Exception, or JumpReg with RegTarget[1:0]!=0: PC<=EXC_VECTOR, EPC<=PC.
  2. ERet: PC<=EPC.
  3. Stall: PC holds.
  4. JumpReg: PC<=RegTarget.
  5. Jump: PC<=PCPlus4[31:28], JumpTarget, 2'b00.
  6. Taken Branch: PC<=PCPlus4 + (sign-extended BranchOffset << 2).
  7. Otherwise: PC<=PCPlus4.
- Misaligned JumpReg:
  - Follows the exception path with EPC<=PC.
  - Misaligned=1 for exactly the following cycle.
  - No RAS change.
  - Misalignment is checked only when Stall=0; a stalled misaligned JumpReg is ignored.
- BrCond encoding (taken when):
  - 000 BEQ: ALUZero.
  - 001 BNE: !ALUZero.
  - 010 BLEZ: ALUZero|ALUNeg.
  - 011 BGTZ: !ALUZero&!ALUNeg.
  - 100 BLTZ: ALUNeg.
  - 101 BGEZ: !ALUNeg.
  - 110/111: never taken.
- Arithmetic: 32-bit modulo; PC wraps from 32'hFFFF_FFFC to 0 with no flag.
- RAS behaviour:
  - Active only on a cycle whose selected source is Jump or JumpReg (no Stall, Exception, ERet or misalignment).
  - Push value is PCPlus4 (delay-slot mode: PC+8).
  - Pop applies only with JumpReg&Return.
  - Pop and push in the same cycle replace the top; count is unchanged.
  - Push when full: the oldest entry is overwritten (circular); count saturates at RAS_DEPTH.
  - Pop when empty: no change; RASEmpty stays 1.
  - RASTop and RASEmpty are registered views of the stack state.
- Exception and ERet asserted together: Exception wins. Exception during Stall is taken.
- Reset mid-operation clears any pending state immediately.

Optional Feature:
- Macro: PCU_DELAY_SLOT_EN.
- Defined (MIPS branch-delay-slot semantics):
  - A taken Jump, JumpReg or Branch latches its target into a pending register; state moves IDLE->PENDING and PC<=PCPlus4 (the delay-slot fetch).
  - The next non-stalled cycle: PC<=pending target, state returns to IDLE. Redirect inputs in that cycle are ignored.
  - Stall in PENDING holds both PC and pending.
  - Exception or ERet in PENDING clears pending and returns to IDLE.
  - The Link push value is PC+8.
- Undefined: redirects take effect on the next edge; no pending state exists.

Test Plan:
- Reset then release, 3 idle cycles -> PC=0x3000, 0x3004, 0x3008, 0x300C; RASEmpty=1; EPC=0.
- At PC=0x3010: Branch, BrCond=001, ALUZero=0, BranchOffset=16'hFFFC -> PC=0x3004. Repeat with ALUZero=1 -> PC=0x3014.
- At PC=0x3000: Jump+Link, JumpTarget=0x000_1000 -> PC=0x4000, RASTop=0x3004. Then JumpReg+Return, RegTarget=0x3004 -> PC=0x3004, RASEmpty=1.
- Five Jump+Link pushes with RAS_DEPTH=4, then four pops -> RASTop follows the last four pushes newest-first; fifth pop leaves RASEmpty=1 and causes no state change.
- At PC=0x3020: JumpReg with RegTarget=0x3002 -> PC=0x4180, EPC=0x3020, Misaligned=1 for one cycle; then ERet -> PC=0x3020.
- With PCU_DELAY_SLOT_EN: at PC=0x3000, Jump to 0x3100 -> PC=0x3004 then 0x3100; Stall=1 held 2 cycles between them -> PC stays 0x3004 for 2 cycles, then 0x3100.
